// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 prefix byte values and receive-FSM state type.
package ps2_pkg;
    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_rx_state_t;
endpackage

// File: rtl/ps2_scan_decoder_if.sv
// ps2_scan_decoder_if: raw PS/2 lines in, decoded key events out.
interface ps2_scan_decoder_if;
    logic       PS2_CLK;
    logic       PS2_DAT;
    logic       valid;
    logic       makeBreak;
    logic [7:0] outCode;
    logic       extended;
    logic       frame_err;
    modport master (output PS2_CLK, PS2_DAT, input valid, makeBreak, outCode, extended, frame_err);
    modport slave  (input PS2_CLK, PS2_DAT, output valid, makeBreak, outCode, extended, frame_err);
endinterface

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronizes and filters the PS/2 lines and deframes 11-bit frames.
// Pulses are combinational in the accepting falling-edge cycle; the caller registers them.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic       o_byte_valid,
    output logic [7:0] o_byte,
    output logic       o_err,
    output logic       o_timeout
);
    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    r_clk_sync, r_dat_sync;
    logic          r_clk_lvl;
    logic [FW-1:0] r_flt;
    ps2_rx_state_t r_state, w_state_n;
    logic [7:0]    r_shift;
    logic [2:0]    r_bit;
    logic          r_par;
    logic [TW-1:0] r_tmo;
    logic          w_flip, w_fe, w_dat;

    assign w_dat  = r_dat_sync[1];
    assign w_flip = (r_clk_sync[1] != r_clk_lvl) && (r_flt == FW'(FILTER_CYCLES - 1));
    assign w_fe   = w_flip && r_clk_lvl;
    assign o_byte = r_shift;
    assign o_timeout = (r_state != IDLE) && !w_fe && (r_tmo == TW'(TIMEOUT_CYCLES - 1));

    // Lines idle high, so the synchronizers and accepted level reset to 1 to avoid a false edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_sync <= 2'b11;
            r_dat_sync <= 2'b11;
            r_clk_lvl  <= 1'b1;
            r_flt      <= '0;
        end else begin
            r_clk_sync <= {r_clk_sync[0], i_ps2_clk};
            r_dat_sync <= {r_dat_sync[0], i_ps2_dat};
            r_flt      <= (r_clk_sync[1] == r_clk_lvl || w_flip) ? '0 : r_flt + FW'(1);
            r_clk_lvl  <= w_flip ? ~r_clk_lvl : r_clk_lvl;
        end
    end

    always_comb begin
        w_state_n    = r_state;
        o_byte_valid = 1'b0;
        o_err        = 1'b0;
        if (o_timeout)
            w_state_n = IDLE;
        else if (w_fe)
            case (r_state)
                IDLE:    w_state_n = w_dat ? IDLE : DATA;
                DATA:    w_state_n = (r_bit == 3'd7) ? PARITY : DATA;
                PARITY:  w_state_n = STOP;
                default: begin
                    w_state_n    = IDLE;
                    o_byte_valid = w_dat && (^{r_shift, r_par});
                    o_err        = !(w_dat && (^{r_shift, r_par}));
                end
            endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_bit   <= '0;
            r_par   <= 1'b0;
            r_tmo   <= '0;
        end else begin
            r_state <= w_state_n;
            r_tmo   <= (w_state_n == IDLE || w_fe) ? '0 : r_tmo + TW'(1);
            if (w_fe && r_state == IDLE) r_bit <= '0;
            if (w_fe && r_state == DATA) begin
                r_shift <= {w_dat, r_shift[7:1]};
                r_bit   <= r_bit + 3'd1;
            end
            if (w_fe && r_state == PARITY) r_par <= w_dat;
        end
    end
endmodule

// File: rtl/ps2_scan_decoder.sv
// ps2_scan_decoder: folds F0/E0 prefix bytes into one registered event per key transition.
module ps2_scan_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input logic               clk,
    input logic               reset,
    ps2_scan_decoder_if.slave bus
);
    logic       w_byte_valid, w_err, w_timeout;
    logic [7:0] w_byte;
    logic       r_valid, r_make, r_ext_out, r_err, r_brk, r_ext;
    logic [7:0] r_code;

    ps2_frame_rx #(
        .FILTER_CYCLES (FILTER_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk         (clk),
        .reset       (reset),
        .i_ps2_clk   (bus.PS2_CLK),
        .i_ps2_dat   (bus.PS2_DAT),
        .o_byte_valid(w_byte_valid),
        .o_byte      (w_byte),
        .o_err       (w_err),
        .o_timeout   (w_timeout)
    );

    assign bus.valid     = r_valid;
    assign bus.makeBreak = r_make;
    assign bus.outCode   = r_code;
    assign bus.extended  = r_ext_out;
    assign bus.frame_err = r_err;

    // An aborted frame drops pending prefixes so a damaged F0 cannot turn a make into a break.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_make    <= 1'b0;
            r_code    <= '0;
            r_ext_out <= 1'b0;
            r_err     <= 1'b0;
            r_brk     <= 1'b0;
            r_ext     <= 1'b0;
        end else begin
            r_valid <= w_byte_valid && w_byte != PS2_BREAK && w_byte != PS2_EXT;
            r_err   <= w_err;
            if (w_err || w_timeout) begin
                r_brk <= 1'b0;
                r_ext <= 1'b0;
            end else if (w_byte_valid) begin
                if (w_byte == PS2_BREAK)
                    r_brk <= 1'b1;
                else if (w_byte == PS2_EXT)
                    r_ext <= 1'b1;
                else begin
                    r_code    <= w_byte;
                    r_make    <= ~r_brk;
                    r_ext_out <= r_ext;
                    r_brk     <= 1'b0;
                    r_ext     <= 1'b0;
                end
            end
        end
    end
endmodule
